biss_master_ctrl: RTL and testbench

//  BiSS-C point-to-point master: sequences one sensor-data frame per trigger on the MA/SLO pair.

---
 rtl/biss_pkg.sv | 31 +++
 rtl/biss_crc6.sv | 27 ++
 rtl/biss_master_ctrl.sv | 202 ++++++++++++++++++++
 tb/tb_biss_master_ctrl.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/biss_pkg.sv
// BiSS-C master shared definitions: FSM states, CRC6 polynomial, frame limits and the
// position sign-extension helper used when publishing a received frame.
package biss_pkg;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_ACK,
        ST_START,
        ST_CDS,
        ST_DATA,
        ST_NE,
        ST_NW,
        ST_CRC,
        ST_TOUT,
        ST_DONE
    } biss_state_t;

    // x^6 term is implicit; 0x43 with the top bit dropped
    localparam logic [5:0] CRC6_POLY = 6'h03;
    localparam int         MAX_BITS  = 32;

    // data holds nbits right-aligned bits (nbits in 1..32)
    function automatic logic [31:0] sign_extend(input logic [31:0] data, input logic [5:0] nbits);
        logic [31:0] mask;
        logic [4:0]  top;
        top  = 5'(nbits - 6'd1);
        mask = (nbits >= 6'(MAX_BITS)) ? '1 : ((32'd1 << nbits) - 32'd1);
        return data[top] ? (data | ~mask) : (data & mask);
    endfunction

endpackage

// File: rtl/biss_crc6.sv
// Serial CRC6 (x^6+x+1, seed 0), one bit per enable, MSB of the message first.
module biss_crc6
    import biss_pkg::*;
(
    input  logic       clk_i,
    input  logic       reset_n_i,
    input  logic       clr_i,
    input  logic       en_i,
    input  logic       bit_i,
    output logic [5:0] crc_o
);

    logic fb;

    assign fb = crc_o[5] ^ bit_i;

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            crc_o <= '0;
        end else if (clr_i) begin
            crc_o <= '0;
        end else if (en_i) begin
            crc_o <= {crc_o[4:0], 1'b0} ^ (fb ? CRC6_POLY : 6'h00);
        end
    end

endmodule

// File: rtl/biss_master_ctrl.sv
// BiSS-C point-to-point master: drives MA, samples SLO on MA rising edges, checks CRC6
// and publishes a sign-extended position with per-frame status flags.
module biss_master_ctrl
    import biss_pkg::*;
#(
    parameter int SYNC_STAGES  = 2,
    parameter int ACK_TIMEOUT  = 255,
    parameter int BUSY_TIMEOUT = 4095
) (
    input  logic        clk_i,
    input  logic        reset_n_i,
    input  logic        enable_i,
    input  logic        trig_i,
    input  logic [7:0]  BITS,
    input  logic [15:0] CLK_HALF,
    output logic        biss_sck_o,
    input  logic        biss_dat_i,
    output logic [31:0] posn_o,
    output logic        posn_valid_o,
    output logic        busy_o,
    output logic        link_up_o,
    output logic        error_o,
    output logic        crc_err_o,
    output logic        timeout_o
);

    localparam logic [15:0] ACK_LIM  = 16'(ACK_TIMEOUT - 1);
    localparam logic [15:0] BUSY_LIM = 16'(BUSY_TIMEOUT - 1);

    logic [1:0]             rst_pipe;
    logic                   rst_n;
    logic [SYNC_STAGES-1:0] dat_sync;
    logic                   sample;

    biss_state_t state;
    logic [15:0] half_cnt, half_r, ack_cnt, busy_cnt;
    logic [5:0]  bits_r, bit_cnt, crc_rx, crc_calc;
    logic [2:0]  crc_cnt;
    logic [31:0] data_sr;
    logic        ne_r, tout_flag, sck;
    logic        active, rise, crc_en, crc_clr, crc_ok;
    logic [5:0]  bits_eff;
    logic [15:0] half_eff;

    // Reset asserts asynchronously but releases on a clock edge
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) rst_pipe <= '0;
        else            rst_pipe <= {rst_pipe[0], 1'b1};
    end
    assign rst_n = rst_pipe[1];

    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) dat_sync <= '1;
        else        dat_sync <= {dat_sync[SYNC_STAGES-2:0], biss_dat_i};
    end
    assign sample = dat_sync[SYNC_STAGES-1];

    assign bits_eff = (BITS == 8'd0) ? 6'd1 :
                      (BITS > 8'(MAX_BITS)) ? 6'(MAX_BITS) : BITS[5:0];
    assign half_eff = (CLK_HALF < 16'd2) ? 16'd2 : CLK_HALF;

    assign active  = state inside {ST_ACK, ST_START, ST_CDS, ST_DATA, ST_NE, ST_NW, ST_CRC};
    assign rise    = active && (half_cnt == '0) && !sck;
    assign crc_en  = rise && (state inside {ST_DATA, ST_NE, ST_NW});
    assign crc_clr = (state == ST_IDLE) && trig_i && enable_i;
    assign crc_ok  = (crc_calc == ~crc_rx);

    biss_crc6 u_crc (
        .clk_i    (clk_i),
        .reset_n_i(rst_n),
        .clr_i    (crc_clr),
        .en_i     (crc_en),
        .bit_i    (sample),
        .crc_o    (crc_calc)
    );

    assign biss_sck_o = sck;
    assign busy_o     = (state != ST_IDLE);

    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            state        <= ST_IDLE;
            sck          <= 1'b1;
            half_cnt     <= '0;
            half_r       <= 16'd2;
            bits_r       <= 6'd1;
            bit_cnt      <= '0;
            crc_cnt      <= '0;
            ack_cnt      <= '0;
            busy_cnt     <= '0;
            data_sr      <= '0;
            crc_rx       <= '0;
            ne_r         <= 1'b0;
            tout_flag    <= 1'b0;
            posn_o       <= '0;
            posn_valid_o <= 1'b0;
            link_up_o    <= 1'b0;
            error_o      <= 1'b0;
            crc_err_o    <= 1'b0;
            timeout_o    <= 1'b0;
        end else begin
            posn_valid_o <= 1'b0;
            if (active) begin
                if (half_cnt != '0) begin
                    half_cnt <= half_cnt - 16'd1;
                end else begin
                    half_cnt <= half_r - 16'd1;
                    sck      <= ~sck;
                end
            end
            // Abort overrides the MA toggle above so the line parks high at once
            if (!enable_i) begin
                if (state != ST_IDLE) begin
                    state <= ST_IDLE;
                    sck   <= 1'b1;
                end
            end else begin
                case (state)
                    ST_IDLE: if (trig_i) begin
                        state     <= ST_ACK;
                        sck       <= 1'b0;
                        half_cnt  <= half_eff - 16'd1;
                        half_r    <= half_eff;
                        bits_r    <= bits_eff;
                        bit_cnt   <= '0;
                        crc_cnt   <= '0;
                        ack_cnt   <= '0;
                        busy_cnt  <= '0;
                        data_sr   <= '0;
                        crc_rx    <= '0;
                        tout_flag <= 1'b0;
                    end
                    ST_ACK: if (rise) begin
                        ack_cnt <= ack_cnt + 16'd1;
                        if (!sample) state <= ST_START;
                        else if (ack_cnt == ACK_LIM) begin
                            tout_flag <= 1'b1;
                            state     <= ST_TOUT;
                        end
                    end
                    ST_START: if (rise) begin
                        ack_cnt <= ack_cnt + 16'd1;
                        if (sample) state <= ST_CDS;
                        else if (ack_cnt == ACK_LIM) begin
                            tout_flag <= 1'b1;
                            state     <= ST_TOUT;
                        end
                    end
                    ST_CDS: if (rise) state <= ST_DATA;
                    ST_DATA: if (rise) begin
                        data_sr <= {data_sr[30:0], sample};
                        if (bit_cnt == bits_r - 6'd1) state <= ST_NE;
                        else bit_cnt <= bit_cnt + 6'd1;
                    end
                    ST_NE: if (rise) begin
                        ne_r  <= sample;
                        state <= ST_NW;
                    end
                    ST_NW: if (rise) state <= ST_CRC;
                    ST_CRC: if (rise) begin
                        crc_rx <= {crc_rx[4:0], sample};
                        if (crc_cnt == 3'd5) state <= ST_TOUT;
                        else crc_cnt <= crc_cnt + 3'd1;
                    end
                    ST_TOUT: begin
                        if (sample) begin
                            state <= ST_DONE;
                        end else if (busy_cnt == BUSY_LIM) begin
                            state     <= ST_IDLE;
                            timeout_o <= 1'b1;
                            link_up_o <= 1'b0;
                            crc_err_o <= 1'b0;
                        end else begin
                            busy_cnt <= busy_cnt + 16'd1;
                        end
                    end
                    ST_DONE: begin
                        state <= ST_IDLE;
                        if (tout_flag) begin
                            timeout_o <= 1'b1;
                            link_up_o <= 1'b0;
                            crc_err_o <= 1'b0;
                        end else if (crc_ok) begin
                            posn_o       <= sign_extend(data_sr, bits_r);
                            posn_valid_o <= 1'b1;
                            error_o      <= ~ne_r;
                            link_up_o    <= 1'b1;
                            crc_err_o    <= 1'b0;
                            timeout_o    <= 1'b0;
                        end else begin
                            crc_err_o <= 1'b1;
                            link_up_o <= 1'b0;
                            timeout_o <= 1'b0;
                        end
                    end
                    default: state <= ST_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_biss_master_ctrl.sv
// Directed bench for biss_master_ctrl with a behavioural BiSS-C encoder on MA/SLO.
module tb_biss_master_ctrl;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        enable = 1'b1;
    logic        trig = 1'b0;
    logic [7:0]  bits = 8'd24;
    logic [15:0] clk_half = 16'd4;
    logic        sck;
    logic        dat = 1'b1;
    logic [31:0] posn;
    logic        posn_valid, busy, link_up, error, crc_err, timeout;

    int nvec = 0;
    int nerr = 0;
    int edge_cnt = 0;
    int pulse_cnt = 0;

    bit enc_q[$];
    bit enc_armed = 1'b0;

    biss_master_ctrl #(.SYNC_STAGES(2), .ACK_TIMEOUT(255), .BUSY_TIMEOUT(4095)) dut (
        .clk_i       (clk),
        .reset_n_i   (reset_n),
        .enable_i    (enable),
        .trig_i      (trig),
        .BITS        (bits),
        .CLK_HALF    (clk_half),
        .biss_sck_o  (sck),
        .biss_dat_i  (dat),
        .posn_o      (posn),
        .posn_valid_o(posn_valid),
        .busy_o      (busy),
        .link_up_o   (link_up),
        .error_o     (error),
        .crc_err_o   (crc_err),
        .timeout_o   (timeout)
    );

    always #4 clk = ~clk;

    always @(posedge sck) edge_cnt++;
    always @(negedge clk) if (posn_valid === 1'b1) pulse_cnt++;

    // Encoder: next SLO bit after each MA rising edge, then busy-low, then idle-high
    always @(posedge sck) begin
        if (enc_armed) begin
            if (enc_q.size() > 0) begin
                #1 dat = enc_q.pop_front();
            end else begin
                enc_armed = 1'b0;
                #1 dat = 1'b0;
                #160 dat = 1'b1;
            end
        end
    end

    task automatic arm_encoder(input int nb, input logic [31:0] val, input logic ne, input logic flip);
        bit msg[$];
        logic [5:0] r;
        logic t, b;
        enc_q.delete();
        for (int i = nb - 1; i >= 0; i--) msg.push_back(val[i]);
        msg.push_back(ne);
        msg.push_back(1'b1);
        r = '0;
        for (int i = 0; i < msg.size() + 6; i++) begin
            b = (i < msg.size()) ? msg[i] : 1'b0;
            t = r[5];
            r = {r[4:0], b};
            if (t) r = r ^ 6'h03;
        end
        r = ~r;
        if (flip) r[0] = ~r[0];
        enc_q.push_back(1'b0);
        enc_q.push_back(1'b1);
        enc_q.push_back(1'b0);
        foreach (msg[i]) enc_q.push_back(msg[i]);
        for (int i = 5; i >= 0; i--) enc_q.push_back(r[i]);
        enc_armed = 1'b1;
    endtask

    task automatic start_frame(input logic [7:0] nb, input logic [15:0] half);
        bits = nb;
        clk_half = half;
        @(negedge clk);
        edge_cnt = 0;
        pulse_cnt = 0;
        trig = 1'b1;
        @(negedge clk);
        trig = 1'b0;
    endtask

    task automatic wait_idle(input int limit);
        int n = 0;
        while (busy === 1'b1 && n < limit) begin
            @(negedge clk);
            n++;
        end
        nvec++;
        if (busy !== 1'b0) begin
            nerr++;
            $display("FAIL wait_idle: busy_o=%b after %0d cycles, required 0", busy, limit);
        end
        repeat (4) @(negedge clk);
    endtask

    task automatic test_reset;
        nvec += 7;
        if (sck !== 1'b1)     begin nerr++; $display("FAIL rst_sck: got %b want 1", sck); end
        if (posn !== 32'h0)   begin nerr++; $display("FAIL rst_posn: got %h want 0", posn); end
        if (busy !== 1'b0)    begin nerr++; $display("FAIL rst_busy: got %b want 0", busy); end
        if (link_up !== 1'b0) begin nerr++; $display("FAIL rst_link: got %b want 0", link_up); end
        if (error !== 1'b0)   begin nerr++; $display("FAIL rst_error: got %b want 0", error); end
        if (crc_err !== 1'b0) begin nerr++; $display("FAIL rst_crc: got %b want 0", crc_err); end
        if (timeout !== 1'b0) begin nerr++; $display("FAIL rst_tout: got %b want 0", timeout); end
    endtask

    task automatic test_good_frame;
        arm_encoder(24, 32'h00800001, 1'b1, 1'b0);
        start_frame(8'd24, 16'd4);
        wait_idle(2000);
        nvec += 6;
        if (posn !== 32'hFF800001) begin nerr++; $display("FAIL good_posn: got %h want ff800001", posn); end
        if (pulse_cnt !== 1)       begin nerr++; $display("FAIL good_pulse: got %0d want 1", pulse_cnt); end
        if (link_up !== 1'b1)      begin nerr++; $display("FAIL good_link: got %b want 1", link_up); end
        if (error !== 1'b0)        begin nerr++; $display("FAIL good_error: got %b want 0", error); end
        if (crc_err !== 1'b0)      begin nerr++; $display("FAIL good_crc: got %b want 0", crc_err); end
        if (edge_cnt !== 36)       begin nerr++; $display("FAIL good_edges: got %0d want 36", edge_cnt); end
    endtask

    task automatic test_crc_error;
        arm_encoder(24, 32'h00800001, 1'b1, 1'b1);
        start_frame(8'd24, 16'd4);
        wait_idle(2000);
        nvec += 5;
        if (crc_err !== 1'b1)      begin nerr++; $display("FAIL crc_flag: got %b want 1", crc_err); end
        if (link_up !== 1'b0)      begin nerr++; $display("FAIL crc_link: got %b want 0", link_up); end
        if (posn !== 32'hFF800001) begin nerr++; $display("FAIL crc_posn: got %h want ff800001", posn); end
        if (pulse_cnt !== 0)       begin nerr++; $display("FAIL crc_pulse: got %0d want 0", pulse_cnt); end
        if (timeout !== 1'b0)      begin nerr++; $display("FAIL crc_tout: got %b want 0", timeout); end
    endtask

    task automatic test_ack_timeout;
        enc_q.delete();
        enc_armed = 1'b0;
        start_frame(8'd24, 16'd2);
        wait_idle(3000);
        nvec += 5;
        if (timeout !== 1'b1)      begin nerr++; $display("FAIL tout_flag: got %b want 1", timeout); end
        if (link_up !== 1'b0)      begin nerr++; $display("FAIL tout_link: got %b want 0", link_up); end
        if (sck !== 1'b1)          begin nerr++; $display("FAIL tout_sck: got %b want 1", sck); end
        if (edge_cnt !== 255)      begin nerr++; $display("FAIL tout_edges: got %0d want 255", edge_cnt); end
        if (posn !== 32'hFF800001) begin nerr++; $display("FAIL tout_posn: got %h want ff800001", posn); end
    endtask

    task automatic test_back_to_back;
        arm_encoder(24, 32'h00123456, 1'b0, 1'b0);
        start_frame(8'd24, 16'd4);
        for (int i = 0; i < 300; i++) begin
            repeat (9) @(negedge clk);
            if (busy !== 1'b1) break;
            trig = 1'b1;
            @(negedge clk);
            trig = 1'b0;
        end
        wait_idle(2000);
        repeat (40) @(negedge clk);
        nvec += 5;
        if (pulse_cnt !== 1)       begin nerr++; $display("FAIL b2b_frames: got %0d want 1", pulse_cnt); end
        if (edge_cnt !== 36)       begin nerr++; $display("FAIL b2b_edges: got %0d want 36", edge_cnt); end
        if (posn !== 32'h00123456) begin nerr++; $display("FAIL b2b_posn: got %h want 00123456", posn); end
        if (error !== 1'b1)        begin nerr++; $display("FAIL b2b_error: got %b want 1", error); end
        if (timeout !== 1'b0)      begin nerr++; $display("FAIL b2b_tout: got %b want 0", timeout); end
    endtask

    task automatic wait_edges(input int target);
        int n = 0;
        while (edge_cnt < target && n < 2000) begin
            @(negedge clk);
            n++;
        end
        nvec++;
        if (edge_cnt < target) begin
            nerr++;
            $display("FAIL wait_edges: got %0d MA edges, required %0d", edge_cnt, target);
        end
    endtask

    task automatic test_abort_and_reset;
        arm_encoder(24, 32'h000F0F0F, 1'b1, 1'b0);
        start_frame(8'd24, 16'd4);
        wait_edges(10);
        enc_armed = 1'b0;
        enable = 1'b0;
        @(negedge clk);
        nvec += 2;
        if (sck !== 1'b1)  begin nerr++; $display("FAIL abort_sck: got %b want 1", sck); end
        if (busy !== 1'b0) begin nerr++; $display("FAIL abort_busy: got %b want 0", busy); end
        dat = 1'b1;
        repeat (6) @(negedge clk);
        nvec += 2;
        if (pulse_cnt !== 0)       begin nerr++; $display("FAIL abort_pulse: got %0d want 0", pulse_cnt); end
        if (posn !== 32'h00123456) begin nerr++; $display("FAIL abort_posn: got %h want 00123456", posn); end
        enable = 1'b1;
        arm_encoder(24, 32'h000F0F0F, 1'b1, 1'b0);
        start_frame(8'd24, 16'd4);
        wait_edges(15);
        #2;
        enc_armed = 1'b0;
        reset_n = 1'b0;
        #1;
        nvec += 3;
        if (sck !== 1'b1)    begin nerr++; $display("FAIL rstmid_sck: got %b want 1", sck); end
        if (busy !== 1'b0)   begin nerr++; $display("FAIL rstmid_busy: got %b want 0", busy); end
        if (posn !== 32'h0)  begin nerr++; $display("FAIL rstmid_posn: got %h want 0", posn); end
        dat = 1'b1;
        @(negedge clk);
        reset_n = 1'b1;
        repeat (6) @(negedge clk);
        arm_encoder(16, 32'h00001234, 1'b1, 1'b0);
        start_frame(8'd16, 16'd4);
        wait_idle(2000);
        nvec += 3;
        if (posn !== 32'h00001234) begin nerr++; $display("FAIL rstmid_posn2: got %h want 00001234", posn); end
        if (link_up !== 1'b1)      begin nerr++; $display("FAIL rstmid_link: got %b want 1", link_up); end
        if (pulse_cnt !== 1)       begin nerr++; $display("FAIL rstmid_pulse: got %0d want 1", pulse_cnt); end
    endtask

    task automatic test_bits_range;
        arm_encoder(32, 32'h7FFFFFFF, 1'b1, 1'b0);
        start_frame(8'd32, 16'd2);
        wait_idle(2000);
        nvec++;
        if (posn !== 32'h7FFFFFFF) begin nerr++; $display("FAIL bits32_posn: got %h want 7fffffff", posn); end
        arm_encoder(1, 32'h1, 1'b1, 1'b0);
        start_frame(8'd1, 16'd2);
        wait_idle(2000);
        nvec += 2;
        if (posn !== 32'hFFFFFFFF) begin nerr++; $display("FAIL bits1_posn: got %h want ffffffff", posn); end
        if (edge_cnt !== 13)       begin nerr++; $display("FAIL bits1_edges: got %0d want 13", edge_cnt); end
        arm_encoder(1, 32'h0, 1'b1, 1'b0);
        start_frame(8'd0, 16'd2);
        wait_idle(2000);
        nvec += 2;
        if (posn !== 32'h0)  begin nerr++; $display("FAIL bits0_posn: got %h want 0", posn); end
        if (edge_cnt !== 13) begin nerr++; $display("FAIL bits0_edges: got %0d want 13", edge_cnt); end
        arm_encoder(32, 32'h80000000, 1'b1, 1'b0);
        start_frame(8'd40, 16'd2);
        wait_idle(2000);
        nvec += 2;
        if (posn !== 32'h80000000) begin nerr++; $display("FAIL bits40_posn: got %h want 80000000", posn); end
        if (edge_cnt !== 44)       begin nerr++; $display("FAIL bits40_edges: got %0d want 44", edge_cnt); end
    endtask

    initial begin
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        repeat (5) @(negedge clk);
        test_reset();
        test_good_frame();
        test_crc_error();
        test_ack_timeout();
        test_back_to_back();
        test_abort_and_reset();
        test_bits_range();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
